// File: rtl/lsu_if.sv
// Core-side request/response channel of the load/store unit.
// The core drives the request through the master modport; the LSU answers
// through the slave modport.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_funct3,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_funct3,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: initiator of the single-port data memory.
// Turns byte-addressed RISC-V loads/stores into word memory cycles. The memory
// has a 1-cycle registered read and no byte enables, so sb/sh go through a
// read-modify-write sequence (ISSUE -> MERGE -> WRITE).
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned half/word
// accesses; when undefined, the low address bits below the access size are
// simply ignored.
module lsu #(
  parameter int MEM_WORDS_LOG2 = 12
) (
  input  logic        clk,
  input  logic        rst,
  lsu_if.slave        bus,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    MERGE   = 3'd3,
    WRITE   = 3'd4,
    RESP    = 3'd5
  } state_t;

  // Request legality: bad funct3, out-of-range address, optional misalignment.
  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic illegal;
    logic out_of_range;
    logic misaligned;
    illegal      = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                   (we && f3[2]);
    out_of_range = (addr >> (MEM_WORDS_LOG2 + 2)) != 32'd0;
`ifdef LSU_ALIGN_CHECK_EN
    misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                   ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    misaligned   = 1'b0;
`endif
    return illegal || out_of_range || misaligned;
  endfunction

  // Little-endian lane extraction with sign/zero extension.
  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    if (lane[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      3'b010:  r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half of the old word, keep the other lanes.
  function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                              input logic [1:0] lane,
                                              input logic [15:0] wd,
                                              input logic [31:0] word);
    logic [31:0] r;
    r = word;
    case (f3)
      3'b000: begin
        case (lane)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      3'b001: begin
        if (lane[1]) begin
          r[31:16] = wd;
        end else begin
          r[15:0] = wd;
        end
      end
      default: r = word;
    endcase
    return r;
  endfunction

  state_t      state_r, state_n;
  logic        we_r, we_n;
  logic [2:0]  funct3_r, funct3_n;
  logic [1:0]  lane_r, lane_n;
  logic [15:0] wdata_r, wdata_n;
  logic        mem_write_en_r, mem_write_en_n;
  logic [31:0] mem_addr_r, mem_addr_n;
  logic [31:0] mem_write_data_r, mem_write_data_n;
  logic        resp_valid_r, resp_valid_n;
  logic [31:0] resp_rdata_r, resp_rdata_n;
  logic        resp_err_r, resp_err_n;

  logic        ready_s;
  logic        accept_s;
  logic        err_s;

  // RESP is the cycle in which IDLE is re-entered, so it accepts like IDLE.
  assign ready_s  = ((state_r == IDLE) || (state_r == RESP)) && !rst;
  assign accept_s = bus.req_valid && ready_s;
  assign err_s    = req_error(bus.req_we, bus.req_funct3, bus.req_addr);

  // Next-state and next-output logic for the memory access sequence.
  always_comb begin
    state_n          = state_r;
    we_n             = we_r;
    funct3_n         = funct3_r;
    lane_n           = lane_r;
    wdata_n          = wdata_r;
    mem_write_en_n   = 1'b0;
    mem_addr_n       = mem_addr_r;
    mem_write_data_n = mem_write_data_r;
    resp_valid_n     = 1'b0;
    resp_rdata_n     = 32'h0000_0000;
    resp_err_n       = 1'b0;

    case (state_r)
      IDLE, RESP: begin
        state_n = IDLE;
        if (accept_s) begin
          we_n     = bus.req_we;
          funct3_n = bus.req_funct3;
          lane_n   = bus.req_addr[1:0];
          wdata_n  = bus.req_wdata[15:0];
          if (err_s) begin
            // Rejected: answer next cycle, memory signals untouched.
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
          end else if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
            // Full word store needs no read.
            state_n          = WRITE;
            mem_write_en_n   = 1'b1;
            mem_addr_n       = {2'b00, bus.req_addr[31:2]};
            mem_write_data_n = bus.req_wdata;
          end else begin
            state_n    = ISSUE;
            mem_addr_n = {2'b00, bus.req_addr[31:2]};
          end
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        if (we_r) begin
          state_n = MERGE;
        end else begin
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        state_n      = RESP;
        resp_valid_n = 1'b1;
        resp_rdata_n = load_extract(funct3_r, lane_r, mem_read_data);
      end
      MERGE: begin
        state_n          = WRITE;
        mem_write_en_n   = 1'b1;
        mem_write_data_n = store_merge(funct3_r, lane_r, wdata_r, mem_read_data);
      end
      WRITE: begin
        state_n      = RESP;
        resp_valid_n = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, captured request fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      we_r             <= 1'b0;
      funct3_r         <= 3'b000;
      lane_r           <= 2'b00;
      wdata_r          <= 16'h0000;
      mem_write_en_r   <= 1'b0;
      mem_addr_r       <= 32'h0000_0000;
      mem_write_data_r <= 32'h0000_0000;
      resp_valid_r     <= 1'b0;
      resp_rdata_r     <= 32'h0000_0000;
      resp_err_r       <= 1'b0;
    end else begin
      state_r          <= state_n;
      we_r             <= we_n;
      funct3_r         <= funct3_n;
      lane_r           <= lane_n;
      wdata_r          <= wdata_n;
      mem_write_en_r   <= mem_write_en_n;
      mem_addr_r       <= mem_addr_n;
      mem_write_data_r <= mem_write_data_n;
      resp_valid_r     <= resp_valid_n;
      resp_rdata_r     <= resp_rdata_n;
      resp_err_r       <= resp_err_n;
    end
  end

  assign bus.req_ready   = ready_s;
  assign bus.resp_valid  = resp_valid_r;
  assign bus.resp_rdata  = resp_rdata_r;
  assign bus.resp_err    = resp_err_r;
  assign mem_write_en    = mem_write_en_r;
  assign mem_addr        = mem_addr_r;
  assign mem_write_data  = mem_write_data_r;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed cases followed by randomized loads/stores,
// checked against a request-level reference model with its own memory image.
module tb_lsu;
  localparam int MEM_BYTES = 4 * (1 << 12);

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clear;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  lsu_if bus_if();

  lsu #(.MEM_WORDS_LOG2(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus_if),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Data memory: 1-cycle registered read, read-first write, no reset.
  logic [31:0] dmem [0:4095];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) dmem[i] <= 32'h0;
      mem_read_data <= 32'h0;
    end else begin
      mem_read_data <= dmem[mem_addr[11:0]];
      if (mem_write_en) dmem[mem_addr[11:0]] <= mem_write_data;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ref_mem [0:4095];
  int n_checks = 0;
  int n_pass = 0;
  int last_lat;
  int last_wait;
  int last_wr_cyc;
  logic [31:0] last_rdata;
  logic last_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Request-level behaviour: outcome, latency and new memory word.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] old,
                       output logic err, output logic [31:0] rd, output logic [31:0] nw,
                       output int lat, output bit wr);
    int lane, hs;
    logic [31:0] b, h;
    bit illegal, range, mis;
    lane = int'(addr % 4);
    hs = 16 * int'((addr / 2) % 2);
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
    range = addr >= MEM_BYTES;
    mis = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    mis = ((f3 % 4) == 1 && addr % 2 != 0) || ((f3 % 4) == 2 && addr % 4 != 0);
`endif
    err = illegal || range || mis;
    rd = 32'h0;
    nw = old;
    wr = 1'b0;
    b = (old >> (8 * lane)) & 32'hFF;
    h = (old >> hs) & 32'hFFFF;
    if (err) begin
      lat = 1;
    end else if (we) begin
      wr = 1'b1;
      if (f3 == 3'd2) begin
        lat = 2;
        nw = wd;
      end else begin
        lat = 4;
        if (f3 == 3'd0) nw = (old & ~(32'hFF << (8 * lane))) | ((wd & 32'hFF) << (8 * lane));
        else nw = (old & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
      end
    end else begin
      lat = 3;
      case (f3)
        3'd0: rd = (b >= 128) ? (b | 32'hFFFFFF00) : b;
        3'd4: rd = b;
        3'd1: rd = (h >= 32768) ? (h | 32'hFFFF0000) : h;
        3'd5: rd = h;
        default: rd = old;
      endcase
    end
  endtask

  // Issue one request (called at a negedge) and check the whole transaction.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    logic e, re;
    logic [31:0] er, nw, wa, wdat, rr, old;
    int lat, guard, wr_n, wr_k, rk, idx;
    bit wr, got_resp, rrdy;
    idx = int'((addr >> 2) % 4096);
    old = ref_mem[idx];
    model(we, f3, addr, wd, old, e, er, nw, lat, wr);
    bus_if.req_valid = 1'b1;
    bus_if.req_we = we;
    bus_if.req_funct3 = f3;
    bus_if.req_addr = addr;
    bus_if.req_wdata = wd;
    guard = 0;
    while (bus_if.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    last_wait = guard;
    if (guard >= 20) begin
      check("ready_wait", 32'd0, 32'd1);
      bus_if.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    wr_n = 0; wr_k = 0; rk = 0; got_resp = 1'b0;
    wa = 32'h0; wdat = 32'h0; rr = 32'h0; re = 1'b0; rrdy = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (mem_write_en === 1'b1) begin
        wr_n++; wr_k = k; wa = mem_addr; wdat = mem_write_data; last_wr_cyc = cyc;
      end
      if (bus_if.resp_valid === 1'b1) begin
        got_resp = 1'b1; rk = k; rr = bus_if.resp_rdata; re = bus_if.resp_err;
        rrdy = bus_if.req_ready;
        break;
      end
      @(negedge clk);
    end
    check("resp_seen", {31'd0, got_resp}, 32'd1);
    if (got_resp) begin
      check("latency", rk, lat);
      check("resp_err", {31'd0, re}, {31'd0, e});
      check("resp_rdata", rr, er);
      check("ready_at_resp", {31'd0, rrdy}, 32'd1);
    end
    check("write_count", wr_n, wr ? 32'd1 : 32'd0);
    if (wr && wr_n == 1) begin
      check("write_cycle", wr_k, lat - 1);
      check("write_addr", wa, addr >> 2);
      check("write_data", wdat, nw);
    end
    if (wr && !e) ref_mem[idx] = nw;
    last_rdata = rr;
    last_err = re;
    last_lat = rk;
  endtask

  initial begin
    int c1, seen_wr, seen_resp;
    logic [31:0] addr, wd;
    logic [2:0] f3;
    logic we;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
    rst = 1'b1;
    mem_clear = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.req_we = 1'b0;
    bus_if.req_funct3 = 3'd0;
    bus_if.req_addr = 32'h0;
    bus_if.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus_if.req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus_if.resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, bus_if.resp_err}, 32'd0);
    check("rst_mem_we", {31'd0, mem_write_en}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    mem_clear = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, bus_if.req_ready}, 32'd1);

    // Test-plan sequence with literal expectations.
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check("sw10_lat", last_lat, 32'd2);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw10", last_rdata, 32'hDEADBEEF);
    do_req(1'b0, 3'b000, 32'h13, 32'h0);
    check("lb13", last_rdata, 32'hFFFFFFDE);
    do_req(1'b0, 3'b100, 32'h13, 32'h0);
    check("lbu13", last_rdata, 32'h000000DE);
    do_req(1'b0, 3'b001, 32'h12, 32'h0);
    check("lh12", last_rdata, 32'hFFFFDEAD);
    do_req(1'b0, 3'b101, 32'h10, 32'h0);
    check("lhu10", last_rdata, 32'h0000BEEF);
    do_req(1'b1, 3'b000, 32'h11, 32'h12345655);
    check("sb11_lat", last_lat, 32'd4);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw10_after_sb", last_rdata, 32'hDEAD55EF);
    do_req(1'b0, 3'b010, 32'h12, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    check("lw12_err", {31'd0, last_err}, 32'd1);
    check("lw12_rdata", last_rdata, 32'h0);
`else
    check("lw12_err", {31'd0, last_err}, 32'd0);
    check("lw12_rdata", last_rdata, 32'hDEAD55EF);
`endif
    do_req(1'b1, 3'b001, 32'h4000, 32'h1234);
    check("sh4000_err", {31'd0, last_err}, 32'd1);
    do_req(1'b0, 3'b011, 32'h10, 32'h0);
    check("f3_011_err", {31'd0, last_err}, 32'd1);

    // Back-to-back: each request is presented during the previous RESP cycle.
    do_req(1'b1, 3'b010, 32'h20, 32'h11111111);
    c1 = last_wr_cyc;
    do_req(1'b1, 3'b010, 32'h24, 32'h22222222);
    check("b2b_accept_wait", last_wait, 32'd0);
    check("b2b_write_gap", last_wr_cyc - c1, 32'd2);
    do_req(1'b0, 3'b010, 32'h20, 32'h0);
    check("b2b_lw_wait", last_wait, 32'd0);
    check("b2b_lw", last_rdata, 32'h11111111);

    // Reset during MERGE of sh 0x10 aborts the store.
    seen_wr = 0; seen_resp = 0;
    bus_if.req_valid = 1'b1;
    bus_if.req_we = 1'b1;
    bus_if.req_funct3 = 3'b001;
    bus_if.req_addr = 32'h10;
    bus_if.req_wdata = 32'h0000AAAA;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    seen_wr += int'(mem_write_en); seen_resp += int'(bus_if.resp_valid);
    @(negedge clk);
    seen_wr += int'(mem_write_en); seen_resp += int'(bus_if.resp_valid);
    rst = 1'b1;
    @(negedge clk);
    seen_wr += int'(mem_write_en); seen_resp += int'(bus_if.resp_valid);
    check("mrst_ready", {31'd0, bus_if.req_ready}, 32'd0);
    check("mrst_resp_rdata", bus_if.resp_rdata, 32'd0);
    check("mrst_resp_err", {31'd0, bus_if.resp_err}, 32'd0);
    check("mrst_mem_addr", mem_addr, 32'd0);
    check("mrst_mem_wdata", mem_write_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    seen_wr += int'(mem_write_en); seen_resp += int'(bus_if.resp_valid);
    check("mrst_ready_after", {31'd0, bus_if.req_ready}, 32'd1);
    check("mrst_no_write", seen_wr, 32'd0);
    check("mrst_no_resp", seen_resp, 32'd0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    check("mrst_word_kept", last_rdata, 32'hDEAD55EF);

    // Randomized traffic over a small window plus occasional out-of-range hits.
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(1, 0));
      f3 = 3'($urandom_range(7, 0));
      addr = 32'($urandom_range(31, 0)) * 32'd4 + 32'($urandom_range(3, 0));
      if ($urandom_range(15, 0) == 0) addr = 32'h4000 + 32'($urandom_range(65535, 0));
      wd = $urandom;
      repeat ($urandom_range(2, 0)) @(negedge clk);
      do_req(we, f3, addr, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
